// File: rtl/cpu_step_ctrl_pkg.sv
// rtl/cpu_step_ctrl_pkg.sv - mode encodings and default widths for the CPU step controller
package cpu_step_ctrl_pkg;

    localparam int DEF_BURST_W = 8;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'd0,
        MODE_BURST = 2'd1,
        MODE_RUN   = 2'd2
    } step_mode_e;

endpackage

// File: rtl/cpu_step_ctrl_burst_counter.sv
// rtl/cpu_step_ctrl_burst_counter.sv - loadable down-counter holding the remaining cycles of a step burst
module step_burst_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         last,
    output logic         zero
);

    logic [W-1:0] count;

    // Clear beats load beats decrement; a zero load value counts as one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= (load_val == '0) ? W'(1) : load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));
    assign zero = (count == '0);

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - halt/run/burst-step FSM producing the MIPS pipeline clock-enable (optional STEP_QUEUE_EN)
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_pulse,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_en,
    output logic               busy,
    output logic [1:0]         mode,
    output logic [CNT_W-1:0]   cycle_cnt
);

    step_mode_e state_q, state_d;
    logic       cnt_clear, cnt_load, cnt_dec;
    logic       cnt_last, cnt_zero;
    logic       burst_done;

`ifdef STEP_QUEUE_EN
    logic       pending_q, pending_d;
`endif

    step_burst_counter #(.W(BURST_W)) u_burst_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (burst_len),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    // An empty counter in BURST is treated as the final cycle so the FSM can never stick.
    assign burst_done = cnt_last | cnt_zero;

    // Next state and burst-counter control; halt_req overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef STEP_QUEUE_EN
        pending_d = pending_q;
`endif
        if (halt_req) begin
            state_d   = MODE_HALT;
            cnt_clear = 1'b1;
`ifdef STEP_QUEUE_EN
            pending_d = 1'b0;
`endif
        end else begin
            case (state_q)
                MODE_HALT: begin
                    if (run_req) begin
                        state_d   = MODE_RUN;
                        cnt_clear = 1'b1;
                    end else if (step_pulse) begin
                        state_d  = MODE_BURST;
                        cnt_load = 1'b1;
                    end
`ifdef STEP_QUEUE_EN
                    pending_d = 1'b0;
`endif
                end
                MODE_BURST: begin
                    if (run_req) begin
                        state_d   = MODE_RUN;
                        cnt_clear = 1'b1;
`ifdef STEP_QUEUE_EN
                        pending_d = 1'b0;
`endif
                    end else if (burst_done) begin
`ifdef STEP_QUEUE_EN
                        // A queued (or just-arrived) step chains straight on with no idle cycle.
                        if (pending_q || step_pulse) begin
                            cnt_load  = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            state_d   = MODE_HALT;
                            cnt_clear = 1'b1;
                        end
`else
                        state_d   = MODE_HALT;
                        cnt_clear = 1'b1;
`endif
                    end else begin
                        cnt_dec = 1'b1;
`ifdef STEP_QUEUE_EN
                        if (step_pulse) begin
                            pending_d = 1'b1;
                        end
`endif
                    end
                end
                MODE_RUN: begin
                    if (!run_req) begin
                        state_d = MODE_HALT;
                    end
`ifdef STEP_QUEUE_EN
                    pending_d = 1'b0;
`endif
                end
                default: begin
                    state_d   = MODE_HALT;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // State register with registered copies of the derived outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MODE_HALT;
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
            mode    <= MODE_HALT;
        end else begin
            state_q <= state_d;
            cpu_en  <= (state_d != MODE_HALT);
            busy    <= (state_d != MODE_HALT);
            mode    <= state_d;
        end
    end

`ifdef STEP_QUEUE_EN
    // One-deep queue of a step request that arrived during a burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    // Enabled-cycle counter for debug display; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    logic        clk;
    logic        reset;
    logic        step_pulse;
    logic        run_req;
    logic        halt_req;
    logic [7:0]  burst_len;
    logic        cpu_en;
    logic        busy;
    logic [1:0]  mode;
    logic [31:0] cycle_cnt;

    int passed;
    int total;
    int en_cnt;
    int guard;
    logic [31:0] cnt0;

    cpu_step_ctrl #(.BURST_W(8), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .step_pulse (step_pulse),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .burst_len  (burst_len),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .mode       (mode),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Fire one step pulse and count enabled cycles over the following window.
    task automatic burst_measure(input logic [7:0] len, input int window, output int cnt);
        burst_len  = len;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        cnt = 0;
        repeat (window) begin
            if (cpu_en) cnt++;
            tick();
        end
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        reset      = 1'b0;
        step_pulse = 1'b0;
        run_req    = 1'b0;
        halt_req   = 1'b0;
        burst_len  = 8'd0;
        tick();
        tick();
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        reset = 1'b1;
        tick();

        // burst of 3
        burst_len  = 8'd3;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        chk("b3_first_en", {31'd0, cpu_en}, 32'd1);
        chk("b3_first_mode", {30'd0, mode}, 32'd1);
        chk("b3_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("b3_third_en", {31'd0, cpu_en}, 32'd1);
        tick();
        chk("b3_end_en", {31'd0, cpu_en}, 32'd0);
        chk("b3_end_mode", {30'd0, mode}, 32'd0);
        chk("b3_cycle_cnt", cycle_cnt, 32'd3);

        // burst_len 0 acts as 1, 255 is the maximum
        burst_measure(8'd0, 6, en_cnt);
        chk("b0_len", en_cnt, 32'd1);
        burst_measure(8'd255, 265, en_cnt);
        chk("b255_len", en_cnt, 32'd255);
        chk("b255_cycle_cnt", cycle_cnt, 32'd259);

        // halt mid-burst, then halt beats run
        burst_len  = 8'd8;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("halt_mode", {30'd0, mode}, 32'd0);
        halt_req = 1'b1;
        run_req  = 1'b1;
        tick();
        chk("halt_run_mode", {30'd0, mode}, 32'd0);
        tick();
        chk("halt_run_en", {31'd0, cpu_en}, 32'd0);
        halt_req = 1'b0;
        run_req  = 1'b0;
        tick();
        chk("halt_no_resume", {31'd0, cpu_en}, 32'd0);

        // free-run for 10 edges with a discarded step pulse at the start
        cnt0       = cycle_cnt;
        burst_len  = 8'd3;
        run_req    = 1'b1;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        chk("run_mode", {30'd0, mode}, 32'd2);
        repeat (9) tick();
        run_req = 1'b0;
        tick();
        chk("run_stop_mode", {30'd0, mode}, 32'd0);
        chk("run_cycles", cycle_cnt - cnt0, 32'd10);
        tick();
        tick();
        chk("run_no_burst", {31'd0, cpu_en}, 32'd0);

        // second pulse mid-burst
        cnt0       = cycle_cnt;
        burst_len  = 8'd2;
        step_pulse = 1'b1;
        tick();
        en_cnt = 0;
        if (cpu_en) en_cnt++;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        repeat (8) begin
            if (cpu_en) en_cnt++;
            tick();
        end
`ifdef STEP_QUEUE_EN
        chk("queue_len", en_cnt, 32'd4);
        chk("queue_cycle_cnt", cycle_cnt - cnt0, 32'd4);
`else
        chk("queue_len", en_cnt, 32'd2);
        chk("queue_cycle_cnt", cycle_cnt - cnt0, 32'd2);
`endif

        // async reset mid-run at cycle_cnt 57
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_req = 1'b1;
        guard = 0;
        while (cycle_cnt < 32'd57 && guard < 200) begin
            tick();
            guard++;
        end
        chk("pre_rst_cnt", cycle_cnt, 32'd57);
        chk("pre_rst_en", {31'd0, cpu_en}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_en", {31'd0, cpu_en}, 32'd0);
        chk("async_rst_mode", {30'd0, mode}, 32'd0);
        chk("async_rst_cnt", cycle_cnt, 32'd0);
        run_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_en", {31'd0, cpu_en}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
